rps_match_ctrl: RTL and testbench
=================================

Name: rps_match_ctrl

Overview:
- Best-of-N match sequencer for two rock-paper-scissors players.
- Collects one move per player per round over valid/ready handshakes and judges each round with a combinational judge sub-module.
- Keeps the score, reports every round result, and declares the match winner once a player reaches ROUNDS_TO_WIN.
- Sits between the player input front-ends and the score display/LED logic.

Parameters:
- ROUNDS_TO_WIN, 2, round wins needed to take the match (best of 2*N-1); must be >= 1.
- TIMEOUT_CYCLES, 1000, cycles allowed for the second move after the first move is latched; 0 disables the timeout.
- SW, $clog2(ROUNDS_TO_WIN+1), score width; derived, do not override.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a new match.
- p1_valid  in  1  player 1 move offered.
- p1_move  in  2  player 1 move (package encoding).
- p1_ready  out  1  controller can accept the player 1 move.
- p2_valid  in  1  player 2 move offered.
- p2_move  in  2  player 2 move.
- p2_ready  out  1  controller can accept the player 2 move.
- round_valid  out  1  one-cycle pulse; round_result is valid in that cycle.
- round_result  out  2  00 draw, 01 player 1 won, 10 player 2 won.
- p1_score  out  SW  player 1 round wins this match.
- p2_score  out  SW  player 2 round wins this match.
- round_cnt  out  8  rounds played including draws; saturates at 255.
- busy  out  1  match in progress (COLLECT or SCORE).
- match_done  out  1  held high in DONE.
- match_winner  out  2  01 player 1, 10 player 2; 00 when not in DONE.

Behaviour:
- Move encoding: ROCK=00, PAPER=01, SCISSORS=10, 11=INVALID.
- Round rules:
  - Paper beats rock, rock beats scissors, scissors beats paper; equal moves are a draw.
  - An INVALID move loses to any valid move; INVALID vs INVALID is a draw.
- Reset: state IDLE; every output 0; latched moves, have1/have2 flags and timer cleared. Reset applies mid-match and wins over all other inputs.
- IDLE:
  - p1_ready=p2_ready=0.
  - start=1 clears scores and round_cnt, then goes to COLLECT.
- COLLECT:
  - p1_ready = ~have1 and p2_ready = ~have2.
  - A move is accepted on valid&&ready at the clock edge, latched, and its have flag set.
  - Both players may be accepted in the same cycle.
  - When both flags are set (after the accepting edge), go to SCORE.
- Timeout:
  - The timer clears on entry to COLLECT and counts while exactly one have flag is set.
  - When the timer reaches TIMEOUT_CYCLES-1 with the other move still not accepted, the missing player's move is forced to INVALID and the state goes to SCORE.
  - If the second move is accepted in that same cycle, the real move is used.
- SCORE, one cycle:
  - The judge evaluates the latched moves.
  - At the next edge: round_result is registered, round_valid=1 for exactly one cycle, the winner's score increments, round_cnt increments (saturating), and the have flags and timer clear.
  - If the incremented score equals ROUNDS_TO_WIN, go to DONE; otherwise return to COLLECT.
- Latency: the edge that accepts the second move, then one more edge, then round_valid is high. New moves can be accepted in the cycle in which round_valid is high.
- DONE:
  - match_done=1; match_winner holds the winner; scores hold; readies are 0.
  - start=1 begins a new match exactly as from IDLE (scores clear, state goes to COLLECT).
- start is ignored in COLLECT and SCORE.
- Moves are never accepted in IDLE, SCORE or DONE.
- Scores never exceed ROUNDS_TO_WIN; draws never end a match.
- busy = (state==COLLECT) || (state==SCORE).

Decomposition:
- Package rps_pkg:
  - move constants ROCK, PAPER, SCISSORS, INVALID;
  - result constants DRAW=00, P1_WIN=01, P2_WIN=10;
  - the state enum IDLE, COLLECT, SCORE, DONE.
- Sub-module rps_round_judge: purely combinational; inputs p1 move [1:0] and p2 move [1:0]; output result [1:0]; implements the round rules above including INVALID.
- The controller instantiates rps_round_judge once, on the latched moves.

Test Plan:
- Reset, start, then p1=ROCK and p2=SCISSORS in the same cycle → p1_ready=p2_ready=0 after the edge; round_valid 2 edges after accept; round_result=01; p1_score=1; round_cnt=1.
- Default ROUNDS_TO_WIN=2: rounds PAPER/PAPER (draw), SCISSORS/PAPER, ROCK/PAPER, PAPER/ROCK → results 00, 01, 10, 01; DONE with match_winner=01, p1_score=2, p2_score=1, round_cnt=4; start then clears all and busy=1.
- TIMEOUT_CYCLES=8: only p1=ROCK accepted → exactly 8 cycles later (counting from the cycle after acceptance) SCORE forces p2 to INVALID; result 01. Repeat with p2_valid arriving on the final timeout cycle → the real move is judged.
- p1=INVALID(11) vs p2=ROCK → result 10. INVALID vs INVALID → 00 with no score change.
- Hold p1_valid high with changing moves across a round → only the first accepted move is used; p1_ready stays 0 until round_valid.
- rst asserted in COLLECT with one move latched → next cycle everything is 0 and the state is IDLE; a later start gives a clean match. start during COLLECT has no effect.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors match controller.
//   - Move encoding:   ROCK, PAPER, SCISSORS, INVALID
//   - Round results:   DRAW, P1_WIN, P2_WIN
//   - Controller FSM:  state_t (IDLE, COLLECT, SCORE, DONE)
package rps_pkg;

  localparam logic [1:0] ROCK     = 2'b00;
  localparam logic [1:0] PAPER    = 2'b01;
  localparam logic [1:0] SCISSORS = 2'b10;
  localparam logic [1:0] INVALID  = 2'b11;

  localparam logic [1:0] DRAW   = 2'b00;
  localparam logic [1:0] P1_WIN = 2'b01;
  localparam logic [1:0] P2_WIN = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    SCORE   = 2'b10,
    DONE    = 2'b11
  } state_t;

endpackage

// File: rtl/rps_match_ctrl_if.sv
// Player handshake and round-result bundle for rps_match_ctrl.
//   p1_valid/p1_move/p1_ready : player 1 move handshake
//   p2_valid/p2_move/p2_ready : player 2 move handshake
//   round_valid/round_result  : one-cycle round result report
// master = player front-end / result consumer side, slave = controller side.
interface rps_match_ctrl_if;

  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;
  logic       round_valid;
  logic [1:0] round_result;

  modport master (
    output p1_valid, p1_move, p2_valid, p2_move,
    input  p1_ready, p2_ready, round_valid, round_result
  );

  modport slave (
    input  p1_valid, p1_move, p2_valid, p2_move,
    output p1_ready, p2_ready, round_valid, round_result
  );

endinterface

// File: rtl/rps_round_judge.sv
// Combinational judge for one rock-paper-scissors round.
//   p1_move [1:0] : player 1 move (package encoding)
//   p2_move [1:0] : player 2 move
//   result  [1:0] : DRAW, P1_WIN or P2_WIN
// An INVALID move loses to any valid move; two INVALIDs draw.
module rps_round_judge
  import rps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] result
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves result
    // unassigned; otherwise synthesis infers a latch.
    result = DRAW;
    if (p1_move == p2_move) begin
      result = DRAW;
    end else if (p1_move == INVALID) begin
      result = P2_WIN;
    end else if (p2_move == INVALID) begin
      result = P1_WIN;
    end else if ((p1_move == PAPER    && p2_move == ROCK)     ||
                 (p1_move == ROCK     && p2_move == SCISSORS) ||
                 (p1_move == SCISSORS && p2_move == PAPER)) begin
      result = P1_WIN;
    end else begin
      result = P2_WIN;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match sequencer.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start               : one-cycle request to begin a match (IDLE/DONE only)
//   bus (slave)         : player move handshakes and round result pulse
//   p1_score, p2_score  : round wins this match
//   round_cnt           : rounds played including draws, saturates at 255
//   busy                : match in progress (COLLECT or SCORE)
//   match_done          : held high in DONE
//   match_winner        : winner while in DONE, otherwise 00
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SW             = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  rps_match_ctrl_if.slave     bus,
  output logic [SW-1:0]       p1_score,
  output logic [SW-1:0]       p2_score,
  output logic [7:0]          round_cnt,
  output logic                busy,
  output logic                match_done,
  output logic [1:0]          match_winner
);

  // Timer only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int             TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [SW-1:0]  WIN    = SW'(ROUNDS_TO_WIN);

  state_t        state;
  logic          have1;
  logic          have2;
  logic [1:0]    m1;
  logic [1:0]    m2;
  logic [TW-1:0] timer;
  logic [1:0]    judged;

  logic acc1;
  logic acc2;
  logic both_next;
  logic timed_out;

  rps_round_judge u_judge (
    .p1_move (m1),
    .p2_move (m2),
    .result  (judged)
  );

  // Readies decode straight from registered state, so they drop on the
  // same edge that accepts a move.
  assign bus.p1_ready = (state == COLLECT) && !have1;
  assign bus.p2_ready = (state == COLLECT) && !have2;

  assign acc1      = bus.p1_valid && bus.p1_ready;
  assign acc2      = bus.p2_valid && bus.p2_ready;
  assign both_next = (have1 || acc1) && (have2 || acc2);
  // A second move accepted on the last timeout cycle takes priority via
  // both_next, so this only fires when the missing move is still absent.
  assign timed_out = TO_EN && (have1 ^ have2) && (timer == T_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: every register, including the latched moves, is reset so a
    // mid-match reset leaves no stale state behind.
    if (rst) begin
      state            <= IDLE;
      have1            <= 1'b0;
      have2            <= 1'b0;
      m1               <= ROCK;
      m2               <= ROCK;
      timer            <= '0;
      p1_score         <= '0;
      p2_score         <= '0;
      round_cnt        <= '0;
      busy             <= 1'b0;
      match_done       <= 1'b0;
      match_winner     <= DRAW;
      bus.round_valid  <= 1'b0;
      bus.round_result <= DRAW;
    end else begin
      bus.round_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            p1_score         <= '0;
            p2_score         <= '0;
            round_cnt        <= '0;
            match_done       <= 1'b0;
            match_winner     <= DRAW;
            bus.round_result <= DRAW;
            have1            <= 1'b0;
            have2            <= 1'b0;
            timer            <= '0;
            busy             <= 1'b1;
            state            <= COLLECT;
          end
        end

        COLLECT: begin
          if (acc1) begin
            m1    <= bus.p1_move;
            have1 <= 1'b1;
          end
          if (acc2) begin
            m2    <= bus.p2_move;
            have2 <= 1'b1;
          end

          if (both_next) begin
            state <= SCORE;
          end else if (timed_out) begin
            if (!have1) m1 <= INVALID;
            if (!have2) m2 <= INVALID;
            have1 <= 1'b1;
            have2 <= 1'b1;
            state <= SCORE;
          end else if (have1 ^ have2) begin
            timer <= timer + TW'(1);
          end
        end

        SCORE: begin
          bus.round_valid  <= 1'b1;
          bus.round_result <= judged;
          have1            <= 1'b0;
          have2            <= 1'b0;
          timer            <= '0;
          if (round_cnt != 8'hFF) round_cnt <= round_cnt + 8'd1;
          state <= COLLECT;

          if (judged == P1_WIN) begin
            p1_score <= p1_score + SW'(1);
            if (p1_score + SW'(1) == WIN) begin
              state        <= DONE;
              busy         <= 1'b0;
              match_done   <= 1'b1;
              match_winner <= P1_WIN;
            end
          end else if (judged == P2_WIN) begin
            p2_score <= p2_score + SW'(1);
            if (p2_score + SW'(1) == WIN) begin
              state        <= DONE;
              busy         <= 1'b0;
              match_done   <= 1'b1;
              match_winner <= P2_WIN;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed self-checking bench for rps_match_ctrl (ROUNDS_TO_WIN=2,
// TIMEOUT_CYCLES=8). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_rps_match_ctrl;
  import rps_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] p1_score;
  logic [1:0] p2_score;
  logic [7:0] round_cnt;
  logic       busy;
  logic       match_done;
  logic [1:0] match_winner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rps_match_ctrl_if bus ();

  rps_match_ctrl #(
    .ROUNDS_TO_WIN  (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .round_cnt    (round_cnt),
    .busy         (busy),
    .match_done   (match_done),
    .match_winner (match_winner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer both moves in one cycle; round_valid must appear one edge after
  // the accepting edge with the expected result.
  task automatic play(input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] exp_res, input string tag);
    bus.p1_valid = 1'b1;
    bus.p1_move  = a;
    bus.p2_valid = 1'b1;
    bus.p2_move  = b;
    step();
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    check({tag, "_rdy_low"}, {bus.p1_ready, bus.p2_ready}, 2'b00);
    check({tag, "_rv_early"}, bus.round_valid, 1'b0);
    step();
    check({tag, "_rv"}, bus.round_valid, 1'b1);
    check({tag, "_res"}, bus.round_result, exp_res);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_flags"},
          {busy, match_done, match_winner, bus.round_valid, bus.round_result,
           bus.p1_ready, bus.p2_ready}, 9'h000);
    check({tag, "_counts"}, {p1_score, p2_score, round_cnt}, 12'h000);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.p1_valid = 1'b0;
    bus.p1_move  = ROCK;
    bus.p2_valid = 1'b0;
    bus.p2_move  = ROCK;

    // Reset state
    step();
    step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();
    check("idle_rdy", {bus.p1_ready, bus.p2_ready}, 2'b00);

    // First round: rock beats scissors
    do_start();
    check("start_busy", busy, 1'b1);
    check("start_rdy", {bus.p1_ready, bus.p2_ready}, 2'b11);
    play(ROCK, SCISSORS, P1_WIN, "r_vs_s");
    check("r_vs_s_score", {p1_score, p2_score, round_cnt}, {2'd1, 2'd0, 8'd1});
    step();
    check("rv_one_cycle", bus.round_valid, 1'b0);

    // start in COLLECT is ignored
    do_start();
    check("start_in_collect", {busy, p1_score, round_cnt}, {1'b1, 2'd1, 8'd1});

    // Reset mid-match with one move latched
    bus.p1_valid = 1'b1;
    bus.p1_move  = ROCK;
    step();
    bus.p1_valid = 1'b0;
    check("one_latched_rdy", {bus.p1_ready, bus.p2_ready}, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("mid_reset");
    bus.p2_valid = 1'b1;
    bus.p2_move  = PAPER;
    step();
    check("idle_no_accept", {busy, bus.p2_ready, bus.round_valid}, 3'b000);
    bus.p2_valid = 1'b0;

    // Full best-of-3 match
    do_start();
    check("match_start", {busy, p1_score, p2_score, round_cnt}, {1'b1, 2'd0, 2'd0, 8'd0});
    play(PAPER, PAPER, DRAW, "p_vs_p");
    check("p_vs_p_score", {p1_score, p2_score, round_cnt}, {2'd0, 2'd0, 8'd1});
    play(SCISSORS, PAPER, P1_WIN, "s_vs_p");
    check("s_vs_p_score", {p1_score, p2_score, round_cnt}, {2'd1, 2'd0, 8'd2});
    play(ROCK, PAPER, P2_WIN, "r_vs_p");
    check("r_vs_p_score", {p1_score, p2_score, round_cnt}, {2'd1, 2'd1, 8'd3});
    play(PAPER, ROCK, P1_WIN, "p_vs_r");
    check("done_state", {match_done, match_winner, busy}, {1'b1, P1_WIN, 1'b0});
    check("done_score", {p1_score, p2_score, round_cnt}, {2'd2, 2'd1, 8'd4});
    check("done_rdy", {bus.p1_ready, bus.p2_ready}, 2'b00);
    bus.p1_valid = 1'b1;
    bus.p2_valid = 1'b1;
    step();
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    check("done_hold", {match_done, match_winner, bus.round_valid}, {1'b1, P1_WIN, 1'b0});
    check("done_hold_score", {p1_score, p2_score, round_cnt}, {2'd2, 2'd1, 8'd4});

    // Restart from DONE
    do_start();
    check("restart", {busy, match_done, match_winner, p1_score, p2_score, round_cnt},
          {1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0});

    // Timeout: only p1 moves, p2 forced to INVALID after 8 cycles
    bus.p1_valid = 1'b1;
    bus.p1_move  = ROCK;
    step();
    bus.p1_valid = 1'b0;
    repeat (7) step();
    check("to_still_collect", {bus.p2_ready, busy, bus.round_valid}, 3'b110);
    step();
    check("to_score", {bus.p2_ready, bus.round_valid}, 2'b00);
    step();
    check("to_rv", {bus.round_valid, bus.round_result}, {1'b1, P1_WIN});
    check("to_score_val", {p1_score, p2_score, round_cnt}, {2'd1, 2'd0, 8'd1});

    // Second move arrives on the last timeout cycle: real move is judged
    bus.p1_valid = 1'b1;
    bus.p1_move  = PAPER;
    step();
    bus.p1_valid = 1'b0;
    repeat (7) step();
    check("late_still_collect", bus.p2_ready, 1'b1);
    bus.p2_valid = 1'b1;
    bus.p2_move  = SCISSORS;
    step();
    bus.p2_valid = 1'b0;
    check("late_score", bus.p2_ready, 1'b0);
    step();
    check("late_rv", {bus.round_valid, bus.round_result}, {1'b1, P2_WIN});
    check("late_score_val", {p1_score, p2_score, round_cnt, busy}, {2'd1, 2'd1, 8'd2, 1'b1});

    // INVALID loses to a valid move, INVALID vs INVALID draws
    play(INVALID, ROCK, P2_WIN, "inv_vs_r");
    check("inv_done", {match_done, match_winner, p2_score}, {1'b1, P2_WIN, 2'd2});
    do_start();
    play(INVALID, INVALID, DRAW, "inv_vs_inv");
    check("inv_inv_score", {p1_score, p2_score, round_cnt}, {2'd0, 2'd0, 8'd1});

    // p1_valid held with changing moves: first accepted move is used
    bus.p1_valid = 1'b1;
    bus.p1_move  = SCISSORS;
    step();
    check("hold_rdy0", bus.p1_ready, 1'b0);
    bus.p1_move = ROCK;
    step();
    check("hold_rdy1", bus.p1_ready, 1'b0);
    bus.p1_move  = PAPER;
    bus.p2_valid = 1'b1;
    bus.p2_move  = ROCK;
    step();
    bus.p2_valid = 1'b0;
    check("hold_rdy2", bus.p1_ready, 1'b0);
    step();
    check("hold_rv", {bus.round_valid, bus.round_result}, {1'b1, P2_WIN});
    check("hold_score", {p1_score, p2_score, round_cnt}, {2'd0, 2'd1, 8'd2});
    check("hold_rdy_on_rv", bus.p1_ready, 1'b1);
    // PAPER is still offered and is accepted at this edge
    step();
    bus.p1_valid = 1'b0;
    check("next_accept", {bus.p1_ready, bus.round_valid}, 2'b00);
    bus.p2_valid = 1'b1;
    bus.p2_move  = ROCK;
    step();
    bus.p2_valid = 1'b0;
    step();
    check("next_rv", {bus.round_valid, bus.round_result}, {1'b1, P1_WIN});
    check("next_score", {p1_score, p2_score, round_cnt}, {2'd1, 2'd1, 8'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
